// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage RV32M divider.
package ex_div_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 5;

  // Reset is asserted when i_reset carries this level.
  localparam logic RESET_ENABLE = 1'b0;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [DATA_W-1:0] ALL_ONES  = '1;
  localparam logic [DATA_W-1:0] INT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // DIV and REM treat operands as two's complement.
  function automatic logic op_is_signed(div_op_e op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic op_is_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU in the EX stage.
// Holds ID/EX and upstream while iterating; divide-by-zero and signed
// overflow finish in one cycle without iterating.
module ex_div
  import ex_div_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic [ADDR_W-1:0] i_regd_addr,
  input  logic              i_flush,
  output logic              o_hold_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic [ADDR_W-1:0] o_regd_addr,
  output logic              o_we
);

  div_state_e state, state_nxt;
  div_op_e    op_in, op_r;

  logic signed [DATA_W-1:0] dividend_s, divisor_s;
  logic [DATA_W-1:0] divisor_r, rem_r, quot_r;
  logic [CNT_W-1:0]  count_r;
  logic              neg_q, neg_r;

  logic              accept, div_zero, div_ovf, last_step;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_nxt, quot_nxt, calc_result, short_result;

  // Unsigned magnitude of a two's complement value; INT_MIN maps to 2^31.
  function automatic logic [DATA_W-1:0] magnitude(logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (v < 0) r = ZERO_WORD - r;
    return r;
  endfunction

  // Sign fix-up applied only when the result leaves the divider.
  function automatic logic [DATA_W-1:0] apply_sign(logic [DATA_W-1:0] v, logic neg);
    return neg ? (ZERO_WORD - v) : v;
  endfunction

  assign op_in      = div_op_e'(i_op);
  assign dividend_s = i_dividend;
  assign divisor_s  = i_divisor;
  assign accept     = (state == DIV_IDLE) && i_start && !i_flush;
  assign div_zero   = (i_divisor == ZERO_WORD);
  assign div_ovf    = op_is_signed(op_in) && (i_dividend == INT_MIN) && (i_divisor == ALL_ONES);
  assign last_step  = (count_r == CNT_W'(DATA_W-1));
  assign o_we       = o_done;

  // Restoring step: trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    trial    = {rem_r, quot_r[DATA_W-1]} - {1'b0, divisor_r};
    rem_nxt  = {rem_r[DATA_W-2:0], quot_r[DATA_W-1]};
    quot_nxt = {quot_r[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      rem_nxt  = trial[DATA_W-1:0];
      quot_nxt = {quot_r[DATA_W-2:0], 1'b1};
    end
    calc_result = op_is_rem(op_r) ? apply_sign(rem_nxt, neg_r) : apply_sign(quot_nxt, neg_q);
  end

  // Results of the one-cycle special cases, taken straight from the inputs.
  always_comb begin
    short_result = op_is_rem(op_in) ? ZERO_WORD : INT_MIN;
    if (div_zero) short_result = op_is_rem(op_in) ? i_dividend : ALL_ONES;
  end

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_reset == RESET_ENABLE) state <= DIV_IDLE;
    else                         state <= state_nxt;
  end

  // Next-state logic; flush overrides everything and aborts to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = (div_zero || div_ovf) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last_step) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (i_flush) state_nxt = DIV_IDLE;
  end

  // Control outputs decoded from state; hold covers the start cycle and all of CALC.
  always_comb begin
    o_hold_req = accept || (state == DIV_CALC);
    o_busy     = (state != DIV_IDLE);
  end

  // Operand latch and iteration registers.
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      op_r      <= op_in;
      divisor_r <= op_is_signed(op_in) ? magnitude(divisor_s) : i_divisor;
      quot_r    <= op_is_signed(op_in) ? magnitude(dividend_s) : i_dividend;
      rem_r     <= ZERO_WORD;
      count_r   <= '0;
      neg_q     <= op_is_signed(op_in) && ((dividend_s < 0) ^ (divisor_s < 0));
      neg_r     <= op_is_signed(op_in) && (dividend_s < 0);
    end else if (state == DIV_CALC) begin
      rem_r   <= rem_nxt;
      quot_r  <= quot_nxt;
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Registered write-back outputs; o_result is loaded on the edge entering DONE.
  always_ff @(posedge i_Clk) begin
    if (i_reset == RESET_ENABLE) begin
      o_done      <= 1'b0;
      o_result    <= ZERO_WORD;
      o_regd_addr <= '0;
    end else begin
      o_done <= (state_nxt == DIV_DONE);
      if (accept) o_regd_addr <= i_regd_addr;
      if (accept && (div_zero || div_ovf))
        o_result <= short_result;
      else if ((state == DIV_CALC) && last_step && !i_flush)
        o_result <= calc_result;
    end
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle RV32M divider in the EX stage, executing DIV, DIVU, REM and REMU. While a division runs, it drives the hold request that freezes the ID/EX pipeline register and the stages upstream of it. It uses a radix-2 restoring algorithm: one quotient bit per cycle, 32 iteration cycles. Divide-by-zero and signed-overflow cases short-circuit without iterating.

## Interface
Parameters:
- none; widths come from shared defines (`RegsDataBus` = 32 bits, `RegsAddrBus` = 5 bits).

Ports:
- i_Clk  in  1  single clock; all state updates on its rising edge
- i_reset  in  1  synchronous, active-low reset (`ResetEnable` = 0)
- i_start  in  1  EX presents a valid divide-class instruction this cycle
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_dividend  in  32  rs1 value
- i_divisor  in  32  rs2 value
- i_regd_addr  in  5  destination register
- i_flush  in  1  abort the current operation (branch/jump taken by an older instruction)
- o_hold_req  out  1  stall request to the pipeline registers; the EX hold logic maps it to `Hold_ID`
- o_busy  out  1  divider is not IDLE
- o_done  out  1  one-cycle pulse; o_result is valid while it is high
- o_result  out  32  quotient or remainder
- o_regd_addr  out  5  latched destination register
- o_we  out  1  register write enable, equal to o_done

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - Latch i_op, i_regd_addr and the operands when i_start=1 and i_flush=0.
  - Signed ops: latch operand magnitudes; neg_q = sign(dividend) XOR sign(divisor); neg_r = sign(dividend).
  - Divisor == 0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU, or the dividend for REM/REMU.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV, 0 for REM.
  - Otherwise: go to CALC with count=0, rem=0, quot=|dividend|.
- CALC (one step per cycle):
  - Form the 33-bit value {rem, quot[31]} minus {1'b0, divisor}.
  - If non-negative: rem takes the difference and a 1 shifts into quot.
  - If negative: rem takes {rem, quot[31]} and a 0 shifts into quot.
  - When count reaches 31, go to DONE.
- DONE:
  - Set o_result: quot for DIV/DIVU, rem for REM/REMU.
  - Negate the result (two's complement) if neg_q (DIV) or neg_r (REM) is set.
  - Return to IDLE on the next edge.
- i_start while not IDLE: ignored. EX never issues one, because the pipeline is held.
- i_flush=1 in any state: go to IDLE at the next edge, with no o_done and no o_we. i_flush has priority over i_start.
- All arithmetic is unsigned 32/33-bit. Sign fix-up is applied only in DONE.

## Timing
- Reset (i_reset=0 at an edge):
  - State goes to IDLE.
  - o_busy, o_done, o_we = 0; o_result = `ZeroWord`; o_regd_addr = 0.
  - An operation in flight is discarded with no write-back.
- o_hold_req is combinational: (IDLE & i_start & ~i_flush) | CALC. It is low in DONE, so the pipeline advances in the same cycle it consumes the result.
- Normal op, start sampled at edge N:
  - Cycles N+1..N+32: CALC.
  - Cycle N+33: DONE, o_done=1.
  - Hold is asserted for 33 cycles: the start cycle plus 32 CALC cycles.
- Short-circuit op, start sampled at edge N:
  - Cycle N+1: DONE.
  - Hold is asserted for 1 cycle.
- o_done, o_we, o_result and o_regd_addr are registered. o_result holds its last value after DONE.
- Back-to-back: a new i_start is accepted in the IDLE cycle immediately after DONE.

## Structure
- Shared defines header additions:
  - `DivOpBus` (1:0)
  - op codes `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`
  - state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`
  - reuse of `ResetEnable`, `ZeroWord`, `Hold_ID`
- Single module with no sub-module. The restoring step is a local combinational block.

## Test plan
- DIVU 100 / 7, start at edge 0 -> o_done at cycle 33 with o_result=14. o_hold_req high for cycles 0-32, low at cycle 33.
- REM 0xFFFFFFF9 (-7) % 2 -> o_result=0xFFFFFFFF (-1). DIV -7 / 2 -> 0xFFFFFFFD (-3).
- DIVU 5 / 0 -> DONE one cycle after start with 0xFFFFFFFF, hold for 1 cycle. REMU 5 % 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, 1-cycle hold. REM of the same operands -> 0.
- Start DIVU 1000 / 3, assert i_flush at CALC count 10 -> IDLE next cycle, no o_done. An immediate new DIVU 9 / 3 -> 3 after 33 cycles.
- Drive i_reset=0 at CALC count 20 -> all outputs zero and o_busy=0 at the next edge, no o_we pulse afterwards.
